full_adder: RTL and testbench

- Parameterised ripple-carry adder: sums two WIDTH-bit operands plus a carry-in, producing a WIDTH-bit sum and a carry-out.
- Outputs are registered, with one cycle of latency and a valid strobe.
- Used as a datapath arithmetic primitive; the default WIDTH=4 matches the nibble datapath.
- Also provides signed-overflow and zero status flags for downstream condition logic.

---
 rtl/full_adder_pkg.sv | 11 +
 rtl/full_adder_bit.sv | 15 +
 rtl/full_adder.sv | 84 ++++++++
 tb/tb_full_adder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared helpers for the ripple-carry adder: legal width bounds and the carry majority function.
package full_adder_pkg;

  localparam int unsigned FA_MIN_WIDTH = 1;
  localparam int unsigned FA_MAX_WIDTH = 64;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell; chained by the top level to form the ripple-carry adder.
module full_adder_bit
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-out, signed-overflow and zero flags.
module full_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  // carry[i] is the carry into cell i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;
  logic             overflow_comb;
  logic             zero_comb;

  assign carry[0] = c_in;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      full_adder_bit u_bit (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (carry[gi]),
        .s    (sum_comb[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  assign overflow_comb = carry[WIDTH-1] ^ carry[WIDTH];
  assign zero_comb     = ~|sum_comb;

  logic             valid_d,    valid_q;
  logic [WIDTH-1:0] sum_d,      sum_q;
  logic             c_out_d,    c_out_q;
  logic             overflow_d, overflow_q;
  logic             zero_d,     zero_q;

  // Data flops only load on a valid beat, so idle-cycle operand garbage never reaches them.
  always_comb begin
    valid_d    = in_valid;
    sum_d      = sum_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    if (in_valid) begin
      sum_d      = sum_comb;
      c_out_d    = carry[WIDTH];
      overflow_d = overflow_comb;
      zero_d     = zero_comb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      sum_q      <= sum_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed and short random checks of full_adder at WIDTH = 4, 1 and 16.
module tb_full_adder;

  logic clk;
  logic rst_n;

  logic        v4, c4, ov4, vo4, co4, oo4, zo4;
  logic [3:0]  a4, b4, s4;
  logic        v1, c1, vo1, co1, oo1, zo1;
  logic [0:0]  a1, b1, s1;
  logic        v16, c16, vo16, co16, oo16, zo16;
  logic [15:0] a16, b16, s16;

  int total = 0;
  int bad   = 0;

  full_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .c_in(c4),
    .out_valid(vo4), .sum(s4), .c_out(co4), .overflow(oo4), .zero(zo4)
  );

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c_in(c1),
    .out_valid(vo1), .sum(s1), .c_out(co1), .overflow(oo1), .zero(zo1)
  );

  full_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .c_in(c16),
    .out_valid(vo16), .sum(s16), .c_out(co16), .overflow(oo16), .zero(zo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed overflow when both operands share a sign that the sum does not.
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic c,
                       output logic [63:0] s, output logic co, output logic ov, output logic z);
    logic [64:0] full;
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    full = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, c};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    z    = (s == 64'd0);
  endtask

  task automatic chk4(input string tag, input logic ev, input logic [3:0] es,
                      input logic ec, input logic eo, input logic ez);
    chk({tag, ".valid"}, {63'd0, vo4}, {63'd0, ev});
    chk({tag, ".sum"},   {60'd0, s4},  {60'd0, es});
    chk({tag, ".c_out"}, {63'd0, co4}, {63'd0, ec});
    chk({tag, ".ovf"},   {63'd0, oo4}, {63'd0, eo});
    chk({tag, ".zero"},  {63'd0, zo4}, {63'd0, ez});
  endtask

  initial begin
    logic [63:0] es4, es1, es16;
    logic        ec4, eo4, ez4, ec1, eo1, ez1, ec16, eo16, ez16;

    rst_n = 1'b1;
    v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    #1 rst_n = 1'b0;

    // Reset held with valid random traffic: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      v4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      v1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      v16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      tick();
      chk4($sformatf("reset%0d", i), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("reset.valid1", {63'd0, vo1}, 64'd0);
      chk("reset.sum16", {48'd0, s16}, 64'd0);
    end

    rst_n = 1'b1;
    v1 = 1'b0; v16 = 1'b0;
    a4 = 4'h3; b4 = 4'h4; c4 = 1'b1; v4 = 1'b1;
    tick();
    chk4("basic", 1'b1, 4'h8, 1'b0, 1'b1, 1'b0);

    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    tick();
    chk4("wrap", 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);

    a4 = 4'h8; b4 = 4'h8; c4 = 1'b0;
    tick();
    chk4("carry0", 1'b1, 4'h0, 1'b1, 1'b1, 1'b1);

    a4 = 4'h2; b4 = 4'h1; c4 = 1'b0;
    tick();
    chk4("hold.load", 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);

    v4 = 1'b0; a4 = 4'h5; b4 = 4'h5; c4 = 1'b1;
    tick();
    chk4("hold.idle", 1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
    a4 = 4'hx; b4 = 4'hx;
    tick();
    chk4("hold.xin", 1'b0, 4'h3, 1'b0, 1'b0, 1'b0);

    // Back-to-back valid beats on all three widths.
    for (int i = 0; i < 5; i++) begin
      v4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      v1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      v16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      model(4, {60'd0, a4}, {60'd0, b4}, c4, es4, ec4, eo4, ez4);
      model(1, {63'd0, a1}, {63'd0, b1}, c1, es1, ec1, eo1, ez1);
      model(16, {48'd0, a16}, {48'd0, b16}, c16, es16, ec16, eo16, ez16);
      tick();
      chk4($sformatf("tput4_%0d", i), 1'b1, es4[3:0], ec4, eo4, ez4);
      chk($sformatf("tput1_%0d.valid", i), {63'd0, vo1}, 64'd1);
      chk($sformatf("tput1_%0d.res", i), {60'd0, zo1, oo1, co1, s1},
          {60'd0, ez1, eo1, ec1, es1[0]});
      chk($sformatf("tput16_%0d.valid", i), {63'd0, vo16}, 64'd1);
      chk($sformatf("tput16_%0d.res", i), {45'd0, zo16, oo16, co16, s16},
          {45'd0, ez16, eo16, ec16, es16[15:0]});
    end

    // Directed width-1 corners: 1+1 overflows, 0+0+1 overflows into -1.
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    a4 = 4'h7; b4 = 4'h0; c4 = 1'b1;
    tick();
    chk("w1.11", {60'd0, zo1, oo1, co1, s1}, {60'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    chk4("max_pos_inc", 1'b1, 4'h8, 1'b0, 1'b1, 1'b0);
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1;
    tick();
    chk("w1.001", {60'd0, zo1, oo1, co1, s1}, {60'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    chk("w16.ffff_inc", {45'd0, zo16, oo16, co16, s16}, {45'd0, 1'b1, 1'b0, 1'b1, 16'h0000});

    // Reset asserted between edges mid-stream.
    v1 = 1'b0; v16 = 1'b0;
    a4 = 4'h6; b4 = 4'h1; c4 = 1'b0; v4 = 1'b1;
    tick();
    chk4("mid.pre", 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    a4 = 4'h4; b4 = 4'h4;
    #2 rst_n = 1'b0;
    #1;
    chk4("mid.async", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk4("mid.held", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    v4 = 1'b0;
    tick();
    chk4("mid.nostale", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    v4 = 1'b1; a4 = 4'h1; b4 = 4'h1; c4 = 1'b0;
    tick();
    chk4("mid.resume", 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
